sirv_gnrl_rr_arbiter: RTL

Round-robin arbiter that shares one valid/ready datapath channel between N requesters, such as a general FIFO or pipe stage fed by several producers. It supports an optional bounded burst lock, so one requester can hold the grant for up to BURST consecutive beats. Output is registered through a single built-in stage, giving 1 beat/cycle throughput and 1-cycle latency. It sits directly in front of the shared buffer and tags every beat with its source index.

---
 rtl/sirv_gnrl_rr_arbiter.sv | 118 +++++++++++
 1 files changed

// File: rtl/sirv_gnrl_rr_arbiter.sv
// Round-robin N:1 valid/ready arbiter with an optional bounded burst lock and a
// single registered output stage that tags each beat with its source index.
module sirv_gnrl_rr_arbiter #(
   parameter int unsigned N     = 4,
   parameter int unsigned DW    = 32,
   parameter int unsigned IDW   = 2,
   parameter int unsigned BURST = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N-1:0]    i_vld,
   output logic [N-1:0]    i_rdy,
   input  logic [N*DW-1:0] i_dat,
   output logic            o_vld,
   input  logic            o_rdy,
   output logic [DW-1:0]   o_dat,
   output logic [IDW-1:0]  o_id
);
   localparam int unsigned SW = IDW + 1;
   localparam int unsigned CW = $clog2(BURST + 1);

   logic [IDW-1:0] r_ptr;
   logic [IDW-1:0] r_owner;
   logic           r_lock;
   logic [CW-1:0]  r_bcnt;
   logic           r_vld;
   logic [DW-1:0]  r_dat;
   logic [IDW-1:0] r_id;

   logic           w_acc;
   logic           w_found;
   logic [IDW-1:0] w_win;
   logic [IDW-1:0] w_start;
   logic [SW-1:0]  w_sum;
   logic [DW-1:0]  w_dat;
   logic           w_cont;
   logic [CW-1:0]  w_bcnt_n;
   logic           w_last;

   function automatic logic [IDW-1:0] f_inc(input logic [IDW-1:0] x);
      return (x == IDW'(N - 1)) ? '0 : x + IDW'(1);
   endfunction

   assign w_acc = ~r_vld | o_rdy;

   // Scan starts at the owner while locked: an idle owner has a clear bit, so
   // the first hit is then naturally the next requester after it.
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      w_start = r_lock ? r_owner : r_ptr;
      for (int unsigned k = 0; k < N; k++) begin
         w_sum = SW'(w_start) + SW'(k);
         if (w_sum >= SW'(N)) w_sum = w_sum - SW'(N);
         if (!w_found && i_vld[w_sum[IDW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[IDW-1:0];
         end
      end
   end

   always_comb begin
      w_dat = '0;
      for (int unsigned k = 0; k < N; k++) begin
         if (w_win == IDW'(k)) w_dat = i_dat[k*DW +: DW];
      end
   end

   always_comb begin
      i_rdy = '0;
      if (!rst && w_acc && w_found) i_rdy[w_win] = 1'b1;
   end

   assign w_cont   = r_lock && (w_win == r_owner);
   assign w_bcnt_n = w_cont ? r_bcnt + CW'(1) : CW'(1);
   assign w_last   = (w_bcnt_n == CW'(BURST));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_ptr   <= '0;
         r_owner <= '0;
         r_lock  <= 1'b0;
         r_bcnt  <= '0;
         r_vld   <= 1'b0;
         r_dat   <= '0;
         r_id    <= '0;
      end else if (w_acc) begin
         if (w_found) begin
            r_vld <= 1'b1;
            r_dat <= w_dat;
            r_id  <= w_win;
            if (w_last) begin
               r_lock <= 1'b0;
               r_ptr  <= f_inc(w_win);
               r_bcnt <= '0;
            end else begin
               r_lock  <= 1'b1;
               r_owner <= w_win;
               r_bcnt  <= w_bcnt_n;
            end
         end else begin
            r_vld <= 1'b0;
            // Owner went idle with nobody else waiting: release the burst.
            if (r_lock) begin
               r_lock <= 1'b0;
               r_ptr  <= f_inc(r_owner);
               r_bcnt <= '0;
            end
         end
      end
   end

   assign o_vld = r_vld;
   assign o_dat = r_dat;
   assign o_id  = r_id;

endmodule
